pc_redirect_unit: RTL

PC_REDIRECT_UNIT -- requirements
Module: pc_redirect_unit

---
 rtl/pc_redirect_unit.sv | 86 ++++++++
 1 files changed

// File: rtl/pc_redirect_unit.sv
// Fetch PC sequencer with branch redirect, pipeline flush and illegal-target HALT.
// Optional redirect counter port and logic are built only when PERF_CNT_EN is defined.
module pc_redirect_unit #(
  parameter int PC_W = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  output logic [PC_W-1:0] PC,
  output logic            Flush_IFID,
  output logic            Flush_IDEX,
  output logic            misalign_err,
  output logic            halted
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]     redirect_cnt
`endif
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic            flush;
  logic            legal;
  logic            active;

  // Word aligned and fully inside the PC_W address space.
  assign legal = (BrPC[1:0] == 2'b00) && ((BrPC >> PC_W) == 32'd0);

  always_comb begin
    state_nxt = state;
    pc_nxt    = PC;
    flush     = 1'b0;
    unique case (state)
      RUN: begin
        if (PcSel) begin
          flush = 1'b1;
          if (legal) pc_nxt = BrPC[PC_W-1:0];
          else       state_nxt = HALT;
        end else if (!stall) begin
          pc_nxt = PC + PC_W'(4);
        end
      end
      HALT: flush = 1'b1;
    endcase
  end

  assign Flush_IFID = flush | ~reset;
  assign Flush_IDEX = flush | ~reset;

  // The first edge after reset release only arms the unit; no state moves on it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= RUN;
      PC           <= '0;
      misalign_err <= 1'b0;
      halted       <= 1'b0;
      active       <= 1'b0;
    end else if (!active) begin
      active <= 1'b1;
    end else begin
      state        <= state_nxt;
      PC           <= pc_nxt;
      halted       <= (state_nxt == HALT);
      misalign_err <= misalign_err | (state_nxt == HALT);
    end
  end

`ifdef PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic accept;
  assign accept = active && (state == RUN) && PcSel && legal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      redirect_cnt <= 32'd0;
    else if (accept) redirect_cnt <= sat_inc(redirect_cnt);
  end
`endif

endmodule
